// File: rtl/ss_wbs_mem_pkg.sv
// Shared types and constants for the ss_wbs_mem Wishbone slave memory target.
// FSM state encoding, statistics counter width and a saturating increment helper.
package ss_wbs_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TERM = 2'd3
  } wbs_state_t;

  localparam int SS_WBS_CNT_W = 16;
  localparam int WAIT_W       = 4;

  localparam logic [SS_WBS_CNT_W-1:0] CNT_ONE = {{(SS_WBS_CNT_W-1){1'b0}}, 1'b1};

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [SS_WBS_CNT_W-1:0] sat_inc(input logic [SS_WBS_CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/ss_wbs_mem_if.sv
// Wishbone slave bus bundle between the DMA master port and the ss_wbs_mem target.
// Handshake: a beat is requested while cyc&stb are high and completes on the clock edge where
// exactly one of ack/err/rty is high; the master holds adr/dat/sel/we stable until then.
interface ss_wbs_mem_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat64_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_cab_i;
  logic [31:0] wbs_dat_o;
  logic [31:0] wbs_dat64_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_dat64_i, wbs_sel_i, wbs_we_i,
           wbs_stb_i, wbs_cyc_i, wbs_cab_i,
    input  wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_dat64_i, wbs_sel_i, wbs_we_i,
           wbs_stb_i, wbs_cyc_i, wbs_cab_i,
    output wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/ss_mem_lane.sv
// One 32-bit data lane: 2**AW words, byte-writable, combinational read.
// Contents are deliberately not reset so the array maps onto plain memory.
module ss_mem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ss_wbs_mem.sv
// Wishbone slave memory target with two lanes, programmable wait states, CAB bursts,
// out-of-window error termination and periodic retry injection for exercising a DMA master.
module ss_wbs_mem
  import ss_wbs_mem_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          AW        = 10,
  parameter int          WAIT_CYC  = 2,
  parameter int          RTY_EVERY = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  ss_wbs_mem_if.slave             wbs,
  output logic [SS_WBS_CNT_W-1:0] stat_rd_cnt,
  output logic [SS_WBS_CNT_W-1:0] stat_wr_cnt,
  output wbs_state_t              dbg_state
);

  localparam logic [WAIT_W-1:0]       WAIT_LOAD = (WAIT_CYC > 0) ? WAIT_W'(WAIT_CYC - 1) : '0;
  localparam bit                      RTY_EN    = (RTY_EVERY != 0);
  localparam logic [SS_WBS_CNT_W-1:0] RTY_LAST  =
    (RTY_EVERY > 0) ? SS_WBS_CNT_W'(RTY_EVERY - 1) : '0;

  wbs_state_t              state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [SS_WBS_CNT_W-1:0] rty_cnt;
  logic                    term_rty;

  logic          req;
  logic          hit;
  logic          retry_now;
  logic          beat_ack;
  logic          beat_err;
  logic          lane_we;
  logic [AW-1:0] word;
  logic [31:0]   rd_dat;
  logic [31:0]   rd_dat64;
  logic          unused_adr_lsb;

  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign hit       = (wbs.wbs_adr_i[31:AW+2] == BASE[31:AW+2]);
  assign word      = wbs.wbs_adr_i[AW+1:2];
  assign retry_now = RTY_EN && (rty_cnt == RTY_LAST);

  // Beat terminations in ACK are combinational so a CAB burst moves one beat per clock.
  assign beat_ack = (state == ST_ACK) & req & hit;
  assign beat_err = (state == ST_ACK) & req & ~hit;
  assign lane_we  = beat_ack & wbs.wbs_we_i;

  assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

  ss_mem_lane #(.AW(AW)) u_lane_dat (
    .clk   (wb_clk_i),
    .we    (lane_we),
    .sel   (wbs.wbs_sel_i),
    .addr  (word),
    .wdata (wbs.wbs_dat_i),
    .rdata (rd_dat)
  );

  ss_mem_lane #(.AW(AW)) u_lane_dat64 (
    .clk   (wb_clk_i),
    .we    (lane_we),
    .sel   (wbs.wbs_sel_i),
    .addr  (word),
    .wdata (wbs.wbs_dat64_i),
    .rdata (rd_dat64)
  );

  assign wbs.wbs_ack_o   = beat_ack;
  assign wbs.wbs_err_o   = beat_err | ((state == ST_TERM) & wbs.wbs_cyc_i & ~term_rty);
  assign wbs.wbs_rty_o   = (state == ST_TERM) & wbs.wbs_cyc_i & term_rty;
  assign wbs.wbs_dat_o   = beat_ack ? rd_dat   : 32'h0;
  assign wbs.wbs_dat64_o = beat_ack ? rd_dat64 : 32'h0;
  assign dbg_state       = state;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      rty_cnt     <= '0;
      term_rty    <= 1'b0;
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (beat_ack) begin
        if (wbs.wbs_we_i) stat_wr_cnt <= sat_inc(stat_wr_cnt);
        else              stat_rd_cnt <= sat_inc(stat_rd_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (req) begin
            if (retry_now) begin
              state    <= ST_TERM;
              term_rty <= 1'b1;
              rty_cnt  <= '0;
            end else begin
              if (RTY_EN) rty_cnt <= rty_cnt + CNT_ONE;
              if (!hit) begin
                state    <= ST_TERM;
                term_rty <= 1'b0;
              end else if (WAIT_CYC > 0) begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_LOAD;
              end else begin
                state <= ST_ACK;
              end
            end
          end
        end

        ST_WAIT: begin
          if (!wbs.wbs_cyc_i)      state    <= ST_IDLE;
          else if (wait_cnt == '0) state    <= ST_ACK;
          else                     wait_cnt <= wait_cnt - 4'd1;
        end

        // A paused burst (stb low, cyc high) simply holds here.
        ST_ACK: begin
          if (!wbs.wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (req && (!hit || !wbs.wbs_cab_i)) begin
            state <= ST_IDLE;
          end
        end

        ST_TERM: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_wbs_mem.sv
// Directed testbench for ss_wbs_mem: wait-state latency, byte lanes, CAB bursts,
// window errors, retry injection, abort and mid-burst reset.
module tb_ss_wbs_mem;
  import ss_wbs_mem_pkg::*;

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_ACK  = 3'b001;
  localparam logic [2:0] T_ERR  = 3'b010;
  localparam logic [2:0] T_RTY  = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr   = '0;
  logic [31:0] dw    = '0;
  logic [31:0] dw64  = '0;
  logic [3:0]  sel   = '0;
  logic        we    = 1'b0;
  logic        stb   = 1'b0;
  logic        cyc   = 1'b0;
  logic        cab   = 1'b0;
  logic        use_b = 1'b0;

  ss_wbs_mem_if bus_a ();
  ss_wbs_mem_if bus_b ();

  assign bus_a.wbs_adr_i   = adr;
  assign bus_a.wbs_dat_i   = dw;
  assign bus_a.wbs_dat64_i = dw64;
  assign bus_a.wbs_sel_i   = sel;
  assign bus_a.wbs_we_i    = we;
  assign bus_a.wbs_stb_i   = stb;
  assign bus_a.wbs_cyc_i   = cyc & ~use_b;
  assign bus_a.wbs_cab_i   = cab;
  assign bus_b.wbs_adr_i   = adr;
  assign bus_b.wbs_dat_i   = dw;
  assign bus_b.wbs_dat64_i = dw64;
  assign bus_b.wbs_sel_i   = sel;
  assign bus_b.wbs_we_i    = we;
  assign bus_b.wbs_stb_i   = stb;
  assign bus_b.wbs_cyc_i   = cyc & use_b;
  assign bus_b.wbs_cab_i   = cab;

  logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
  wbs_state_t  st_a, st_b;

  ss_wbs_mem #(.BASE(32'h0), .AW(10), .WAIT_CYC(2), .RTY_EVERY(0)) dut_a (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .wbs         (bus_a.slave),
    .stat_rd_cnt (rd_cnt_a),
    .stat_wr_cnt (wr_cnt_a),
    .dbg_state   (st_a)
  );

  ss_wbs_mem #(.BASE(32'h0), .AW(10), .WAIT_CYC(1), .RTY_EVERY(3)) dut_b (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .wbs         (bus_b.slave),
    .stat_rd_cnt (rd_cnt_b),
    .stat_wr_cnt (wr_cnt_b),
    .dbg_state   (st_b)
  );

  logic        ack, err, rty;
  logic [31:0] dr, dr64;
  assign ack  = use_b ? bus_b.wbs_ack_o   : bus_a.wbs_ack_o;
  assign err  = use_b ? bus_b.wbs_err_o   : bus_a.wbs_err_o;
  assign rty  = use_b ? bus_b.wbs_rty_o   : bus_a.wbs_rty_o;
  assign dr   = use_b ? bus_b.wbs_dat_o   : bus_a.wbs_dat_o;
  assign dr64 = use_b ? bus_b.wbs_dat64_o : bus_a.wbs_dat64_o;

  int vectors = 0;
  int errors  = 0;

  // ---------------- scoreboard / burst buffers ----------------
  logic [63:0] exp_q[$];
  logic [31:0] bd [8];
  logic [31:0] bd64 [8];
  logic [2:0]  bt_term [8];
  int          bt_lat [8];
  logic [31:0] bt_r [8];
  logic [31:0] bt_r64 [8];

  // ---------------- driver tasks ----------------
  task automatic wb_single(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] d64, input logic [3:0] s,
                           output logic [2:0] term, output int lat,
                           output logic [31:0] r, output logic [31:0] r64);
    @(posedge clk); #1;
    adr = a; dw = d; dw64 = d64; sel = s; we = w; cab = 1'b0; cyc = 1'b1; stb = 1'b1;
    term = T_NONE; lat = -1; r = '0; r64 = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack || err || rty) begin
        term = {rty, err, ack}; lat = n; r = dr; r64 = dr64;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_burst(input logic w, input logic [31:0] a0, input int beats);
    for (int i = 0; i < 8; i++) begin
      bt_term[i] = T_NONE; bt_lat[i] = -1; bt_r[i] = '0; bt_r64[i] = '0;
    end
    @(posedge clk); #1;
    adr = a0; dw = bd[0]; dw64 = bd64[0]; sel = 4'hF; we = w;
    cab = 1'b1; cyc = 1'b1; stb = 1'b1;
    for (int b = 0; b < beats; b++) begin
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (ack || err || rty) begin
          bt_term[b] = {rty, err, ack}; bt_lat[b] = n; bt_r[b] = dr; bt_r64[b] = dr64;
          break;
        end
      end
      @(posedge clk); #1;
      if (bt_term[b] != T_ACK) break;
      if (b < beats - 1) begin
        adr = a0 + 32'(4 * (b + 1)); dw = bd[b+1]; dw64 = bd64[b+1];
      end
    end
    cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; use_b = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ack, err, rty, dr, dr64} !== 67'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {ack, err, rty, dr, dr64});
    end
    vectors++;
    if ({rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b} !== 64'd0) begin
      errors++; $display("FAIL reset_stats: got %h expected 0", {rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b});
    end
    vectors++;
    if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d/%0d expected %0d", st_a, st_b, ST_IDLE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_rw();
    logic [2:0] t; int l; logic [31:0] r, r64;
    wb_single(1'b1, 32'h10, 32'hDEADBEEF, 32'h01234567, 4'hF, t, l, r, r64);
    vectors++;
    if (t !== T_ACK || l !== 3) begin
      errors++; $display("FAIL single_write: got term %b lat %0d expected term %b lat 3", t, l, T_ACK);
    end
    wb_single(1'b0, 32'h10, 32'h0, 32'h0, 4'hF, t, l, r, r64);
    vectors++;
    if (t !== T_ACK || l !== 3) begin
      errors++; $display("FAIL single_read_lat: got term %b lat %0d expected term %b lat 3", t, l, T_ACK);
    end
    vectors++;
    if (r !== 32'hDEADBEEF || r64 !== 32'h01234567) begin
      errors++; $display("FAIL single_read_data: got %h/%h expected deadbeef/01234567", r, r64);
    end
    vectors++;
    if (wr_cnt_a !== 16'd1 || rd_cnt_a !== 16'd1) begin
      errors++; $display("FAIL single_stats: got wr %0d rd %0d expected 1/1", wr_cnt_a, rd_cnt_a);
    end
  endtask

  task automatic test_byte_sel();
    logic [2:0] t; int l; logic [31:0] r, r64;
    wb_single(1'b1, 32'h10, 32'h0000AA00, 32'h0000BB00, 4'b0010, t, l, r, r64);
    vectors++;
    if (t !== T_ACK) begin
      errors++; $display("FAIL bytesel_write: got term %b expected %b", t, T_ACK);
    end
    wb_single(1'b0, 32'h10, 32'h0, 32'h0, 4'hF, t, l, r, r64);
    vectors++;
    if (r !== 32'hDEADAAEF || r64 !== 32'h0123BB67) begin
      errors++; $display("FAIL bytesel_read: got %h/%h expected deadaaef/0123bb67", r, r64);
    end
  endtask

  task automatic test_cab_burst();
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      bd[i]   = 32'hA500_0000 | 32'(i * 32'h0101);
      bd64[i] = 32'h5A00_0000 | 32'(i * 32'h1010);
    end
    wb_burst(1'b1, 32'h20, 8);
    for (int b = 0; b < 8; b++) begin
      vectors++;
      if (bt_term[b] !== T_ACK || bt_lat[b] !== ((b == 0) ? 3 : 0)) begin
        errors++;
        $display("FAIL burst_wr_beat%0d: got term %b lat %0d expected term %b lat %0d",
                 b, bt_term[b], bt_lat[b], T_ACK, (b == 0) ? 3 : 0);
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back({bd64[i], bd[i]});
    wb_burst(1'b0, 32'h20, 8);
    for (int b = 0; b < 8; b++) begin
      e = exp_q.pop_front();
      vectors++;
      if (bt_term[b] !== T_ACK || {bt_r64[b], bt_r[b]} !== e || bt_lat[b] !== ((b == 0) ? 3 : 0)) begin
        errors++;
        $display("FAIL burst_rd_beat%0d: got term %b lat %0d data %h expected ack lat %0d data %h",
                 b, bt_term[b], bt_lat[b], {bt_r64[b], bt_r[b]}, (b == 0) ? 3 : 0, e);
      end
    end
    vectors++;
    if (wr_cnt_a !== 16'd10 || rd_cnt_a !== 16'd10) begin
      errors++; $display("FAIL burst_stats: got wr %0d rd %0d expected 10/10", wr_cnt_a, rd_cnt_a);
    end
  endtask

  task automatic test_window_err();
    logic [2:0] t; int l; logic [31:0] r, r64;
    wb_single(1'b0, 32'h1000, 32'h0, 32'h0, 4'hF, t, l, r, r64);
    vectors++;
    if (t !== T_ERR || l !== 1 || r !== 32'h0) begin
      errors++; $display("FAIL window_err: got term %b lat %0d dat %h expected term %b lat 1 dat 0", t, l, r, T_ERR);
    end
    wb_burst(1'b0, 32'hFFC, 2);
    vectors++;
    if (bt_term[0] !== T_ACK || bt_lat[0] !== 3) begin
      errors++; $display("FAIL edge_burst_beat0: got term %b lat %0d expected %b lat 3", bt_term[0], bt_lat[0], T_ACK);
    end
    vectors++;
    if (bt_term[1] !== T_ERR || bt_lat[1] !== 0 || bt_r[1] !== 32'h0) begin
      errors++;
      $display("FAIL edge_burst_beat1: got term %b lat %0d dat %h expected %b lat 0 dat 0", bt_term[1], bt_lat[1], bt_r[1], T_ERR);
    end
    vectors++;
    if (rd_cnt_a !== 16'd11 || wr_cnt_a !== 16'd10) begin
      errors++; $display("FAIL err_stats: got rd %0d wr %0d expected 11/10", rd_cnt_a, wr_cnt_a);
    end
  endtask

  task automatic test_retry();
    logic [2:0] t; int l; logic [31:0] r, r64;
    logic [2:0] et; int el;
    use_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_single(1'b0, 32'h0, 32'h0, 32'h0, 4'hF, t, l, r, r64);
      et = (i == 2 || i == 5) ? T_RTY : T_ACK;
      el = (i == 2 || i == 5) ? 1 : 2;
      vectors++;
      if (t !== et || l !== el) begin
        errors++; $display("FAIL retry_cycle%0d: got term %b lat %0d expected term %b lat %0d", i + 1, t, l, et, el);
      end
    end
    vectors++;
    if (rd_cnt_b !== 16'd4 || wr_cnt_b !== 16'd0) begin
      errors++; $display("FAIL retry_stats: got rd %0d wr %0d expected 4/0", rd_cnt_b, wr_cnt_b);
    end
    use_b = 1'b0;
  endtask

  task automatic test_abort_reset();
    logic [2:0] t; int l; logic [31:0] r, r64; bit seen;
    @(posedge clk); #1;
    adr = 32'h10; dw = 32'h55555555; dw64 = 32'h55555555; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (st_a !== ST_WAIT) begin
      errors++; $display("FAIL abort_in_wait: got state %0d expected %0d", st_a, ST_WAIT);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    vectors++;
    if (st_a !== ST_IDLE || {ack, err, rty} !== 3'b000 || wr_cnt_a !== 16'd10) begin
      errors++; $display("FAIL abort_idle: got state %0d term %b wr %0d expected %0d 000 10", st_a, {ack, err, rty}, wr_cnt_a, ST_IDLE);
    end
    we = 1'b0;
    wb_single(1'b0, 32'h10, 32'h0, 32'h0, 4'hF, t, l, r, r64);
    vectors++;
    if (t !== T_ACK || r !== 32'hDEADAAEF || r64 !== 32'h0123BB67) begin
      errors++; $display("FAIL abort_mem: got term %b data %h/%h expected ack deadaaef/0123bb67", t, r, r64);
    end

    wb_single(1'b1, 32'h40, 32'h11111111, 32'h22222222, 4'hF, t, l, r, r64);
    bd[0] = 32'h99999999; bd64[0] = 32'h88888888;
    @(posedge clk); #1;
    adr = 32'h40; dw = bd[0]; dw64 = bd64[0]; sel = 4'hF; we = 1'b1;
    cab = 1'b1; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL rst_burst_ack: got no ack expected ack within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, err, rty, dr, dr64} !== 67'd0 || st_a !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_burst: got outs %h state %0d expected 0 state %0d", {ack, err, rty, dr, dr64}, st_a, ST_IDLE);
    end
    @(negedge clk);
    vectors++;
    if (rd_cnt_a !== 16'd0 || wr_cnt_a !== 16'd0) begin
      errors++; $display("FAIL rst_stats: got rd %0d wr %0d expected 0/0", rd_cnt_a, wr_cnt_a);
    end
    cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_single(1'b0, 32'h40, 32'h0, 32'h0, 4'hF, t, l, r, r64);
    vectors++;
    if (t !== T_ACK || l !== 3 || r !== 32'h11111111 || r64 !== 32'h22222222) begin
      errors++; $display("FAIL rst_mem: got term %b lat %0d data %h/%h expected ack lat 3 11111111/22222222", t, l, r, r64);
    end
    vectors++;
    if (rd_cnt_a !== 16'd1) begin
      errors++; $display("FAIL rst_stats_after: got rd %0d expected 1", rd_cnt_a);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_rw();
    test_byte_sel();
    test_cab_burst();
    test_window_err();
    test_retry();
    test_abort_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
